// File: rtl/prog_loader.sv
// prog_loader: assembles a little-endian byte stream into 32-bit words and writes them
// through the data-memory load port while holding the core stopped.
// Define PROG_LOADER_CHECKSUM_EN to require and check a trailing 8-bit sum byte.
module prog_loader #(
   parameter int ADDR_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic [ADDR_W-1:0] base_i,
   input  logic [CNT_W-1:0]  count_i,
   input  logic              in_valid_i,
   input  logic [7:0]        in_data_i,
   output logic              in_ready_o,
   output logic              ld_o,
   output logic [31:0]       wd_o,
   output logic [ADDR_W-1:0] a_o,
   output logic              cpu_hold_o,
   output logic              busy_o,
   output logic              done_o,
   output logic              err_o
);

   // state | meaning
   // IDLE  | waiting for start, core released
   // RECV  | collecting the four bytes of the current word
   // WRITE | one-cycle ld strobe for the assembled word
   // CHECK | consuming the trailing checksum byte
   // DONE  | one-cycle completion pulse
`ifdef PROG_LOADER_CHECKSUM_EN
   typedef enum logic [2:0] {IDLE, RECV, WRITE, CHECK, DONE} state_t;
   localparam state_t TAIL = CHECK;
`else
   typedef enum logic [2:0] {IDLE, RECV, WRITE, DONE} state_t;
   localparam state_t TAIL = DONE;
`endif

   state_t            state_q, state_d;
   logic [1:0]        byte_idx_q, byte_idx_d;
   logic [CNT_W-1:0]  words_left_q, words_left_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       word_q, word_d;
   logic              in_ready_q, in_ready_d;
   logic              ld_q, ld_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              accept;
   logic              last_word;
`ifdef PROG_LOADER_CHECKSUM_EN
   logic [7:0]        csum_q, csum_d;
   logic              err_q, err_d;
`endif

   assign accept    = in_valid_i && in_ready_q;
   assign last_word = (words_left_q == CNT_W'(1));

   always_comb begin
      state_d      = state_q;
      byte_idx_d   = byte_idx_q;
      words_left_d = words_left_q;
      addr_d       = addr_q;
      word_d       = word_q;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_d       = csum_q;
      err_d        = err_q;
`endif
      case (state_q)
         IDLE: begin
            if (start_i) begin
               addr_d       = base_i & ~ADDR_W'(3);
               words_left_d = count_i;
               byte_idx_d   = 2'd0;
`ifdef PROG_LOADER_CHECKSUM_EN
               csum_d       = 8'd0;
               err_d        = 1'b0;
`endif
               state_d      = (count_i != '0) ? RECV : TAIL;
            end
         end
         RECV: begin
            if (accept) begin
               word_d[{byte_idx_q, 3'b000} +: 8] = in_data_i;
               byte_idx_d = byte_idx_q + 2'd1;
`ifdef PROG_LOADER_CHECKSUM_EN
               csum_d     = csum_q + in_data_i;
`endif
               if (byte_idx_q == 2'd3) state_d = WRITE;
            end
         end
         WRITE: begin
            // a_o stays on the current word's address this cycle; advance for the next one
            addr_d       = addr_q + ADDR_W'(4);
            words_left_d = words_left_q - CNT_W'(1);
            state_d      = last_word ? TAIL : RECV;
         end
`ifdef PROG_LOADER_CHECKSUM_EN
         CHECK: begin
            if (accept) begin
               err_d   = (in_data_i != csum_q);
               state_d = DONE;
            end
         end
`endif
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Flag outputs are registered from the next state so they line up with it
      in_ready_d = (state_d == RECV);
`ifdef PROG_LOADER_CHECKSUM_EN
      if (state_d == CHECK) in_ready_d = 1'b1;
`endif
      ld_d   = (state_d == WRITE);
      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q      <= IDLE;
         byte_idx_q   <= 2'd0;
         words_left_q <= '0;
         addr_q       <= '0;
         word_q       <= '0;
         in_ready_q   <= 1'b0;
         ld_q         <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
         csum_q       <= 8'd0;
         err_q        <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         byte_idx_q   <= byte_idx_d;
         words_left_q <= words_left_d;
         addr_q       <= addr_d;
         word_q       <= word_d;
         in_ready_q   <= in_ready_d;
         ld_q         <= ld_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
`ifdef PROG_LOADER_CHECKSUM_EN
         csum_q       <= csum_d;
         err_q        <= err_d;
`endif
      end
   end

   assign in_ready_o = in_ready_q;
   assign ld_o       = ld_q;
   assign wd_o       = word_q;
   assign a_o        = addr_q;
   assign cpu_hold_o = busy_q;
   assign busy_o     = busy_q;
   assign done_o     = done_q;
`ifdef PROG_LOADER_CHECKSUM_EN
   assign err_o      = err_q;
`else
   assign err_o      = 1'b0;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: scoreboard of expected (address, word) writes.
module tb_prog_loader;
   localparam int ADDR_W = 32;
   localparam int CNT_W  = 16;

   logic              clk_i = 1'b0;
   logic              rst_i = 1'b0;
   logic              start_i = 1'b0;
   logic [ADDR_W-1:0] base_i = '0;
   logic [CNT_W-1:0]  count_i = '0;
   logic              in_valid_i = 1'b0;
   logic [7:0]        in_data_i = '0;
   logic              in_ready_o, ld_o, cpu_hold_o, busy_o, done_o, err_o;
   logic [31:0]       wd_o;
   logic [ADDR_W-1:0] a_o;

   prog_loader #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .base_i(base_i),
      .count_i(count_i), .in_valid_i(in_valid_i), .in_data_i(in_data_i),
      .in_ready_o(in_ready_o), .ld_o(ld_o), .wd_o(wd_o), .a_o(a_o),
      .cpu_hold_o(cpu_hold_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct packed {
      logic [ADDR_W-1:0] a;
      logic [31:0]       wd;
   } exp_t;

   exp_t       sb_q[$];
   exp_t       mon_e;
   int         n_chk = 0;
   int         n_err = 0;
   int         cyc_n = 0;
   int         t_start = 0;
   int         done_cyc = 0;
   bit         done_seen = 1'b0;
   bit         load_active = 1'b0;
   bit         rdy_seen = 1'b0;
   bit         mon_en = 1'b0;
   logic [7:0] csum = '0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk_i) begin
      cyc_n++;
      if (mon_en) begin
         chk("rdy_ld_excl", 64'(in_ready_o & ld_o), 64'd0);
         if (in_ready_o) rdy_seen = 1'b1;
         if (ld_o) begin
            if (sb_q.size() == 0) chk("ld_unexpected", 64'(ld_o), 64'd0);
            else begin
               mon_e = sb_q.pop_front();
               chk("ld_addr", 64'(a_o), 64'(mon_e.a));
               chk("ld_data", 64'(wd_o), 64'(mon_e.wd));
            end
         end
         if (load_active) begin
            chk("cpu_hold", 64'(cpu_hold_o), 64'd1);
            chk("busy", 64'(busy_o), 64'd1);
         end
         if (done_o) begin
            done_seen   = 1'b1;
            done_cyc    = cyc_n;
            load_active = 1'b0;
         end
      end
   end

   task automatic do_start(input logic [ADDR_W-1:0] base, input logic [CNT_W-1:0] cnt);
      start_i   = 1'b1;
      base_i    = base;
      count_i   = cnt;
      done_seen = 1'b0;
      rdy_seen  = 1'b0;
      @(posedge clk_i); #1;
      start_i     = 1'b0;
      t_start     = cyc_n;
      load_active = 1'b1;
      csum        = 8'd0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      in_valid_i = 1'b1;
      in_data_i  = b;
      while (!in_ready_o && n < 100) begin
         @(posedge clk_i); #1;
         n++;
      end
      if (!in_ready_o) chk("rdy_timeout", 64'(in_ready_o), 64'd1);
      @(posedge clk_i); #1;
      in_valid_i = 1'b0;
      csum       = csum + b;
   endtask

   task automatic wait_done(input int exp_lat);
      int n = 0;
      while (!done_seen && n < 500) begin
         @(negedge clk_i);
         n++;
      end
      chk("done_seen", 64'(done_seen), 64'd1);
      chk("done_latency", 64'(done_cyc - t_start), 64'(exp_lat));
      @(posedge clk_i); #1;
      chk("done_pulse", 64'(done_o), 64'd0);
      chk("idle_busy", 64'(busy_o), 64'd0);
      chk("idle_hold", 64'(cpu_hold_o), 64'd0);
      chk("idle_rdy", 64'(in_ready_o), 64'd0);
      chk("sb_empty", 64'(sb_q.size()), 64'd0);
   endtask

   // stall_at: byte index preceded by 3 idle cycles; ign_at: byte index preceded by a stray start
   task automatic load_words(input logic [ADDR_W-1:0] base, input int n,
                             input logic [31:0] w0, input logic [31:0] w1,
                             input int stall_at, input int ign_at);
      logic [ADDR_W-1:0] ab;
      logic [31:0]       w;
      logic [7:0]        s;
      exp_t              e;
      int                extra = 0;
      ab = base & ~ADDR_W'(3);
      do_start(base, CNT_W'(n));
      for (int k = 0; k < n; k++) begin
         w    = (k == 0) ? w0 : w1;
         e.a  = ab + ADDR_W'(4 * k);
         e.wd = w;
         sb_q.push_back(e);
         for (int j = 0; j < 4; j++) begin
            if (4 * k + j == stall_at) begin
               repeat (3) @(posedge clk_i);
               #1;
               extra += 3;
            end
            if (4 * k + j == ign_at) begin
               start_i = 1'b1;
               base_i  = 32'h0000_0040;
               count_i = 16'd7;
               @(posedge clk_i); #1;
               start_i = 1'b0;
               extra  += 1;
            end
            send_byte(w[8*j +: 8]);
         end
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      s = csum;
      send_byte(s);
      extra += 1;
`endif
      wait_done(5 * n + 1 + extra);
`ifdef PROG_LOADER_CHECKSUM_EN
      chk("err_good_sum", 64'(err_o), 64'd0);
`endif
   endtask

   task automatic chk_reset_outputs();
      chk("rst_in_ready", 64'(in_ready_o), 64'd0);
      chk("rst_ld", 64'(ld_o), 64'd0);
      chk("rst_wd", 64'(wd_o), 64'd0);
      chk("rst_a", 64'(a_o), 64'd0);
      chk("rst_hold", 64'(cpu_hold_o), 64'd0);
      chk("rst_busy", 64'(busy_o), 64'd0);
      chk("rst_done", 64'(done_o), 64'd0);
      chk("rst_err", 64'(err_o), 64'd0);
   endtask

   initial begin
      repeat (3) @(posedge clk_i);
      #1;
      rst_i  = 1'b1;
      mon_en = 1'b1;
      chk_reset_outputs();

      // reset in the middle of a word
      do_start(32'h0000_0200, 16'd2);
      send_byte(8'hAA);
      send_byte(8'hBB);
      load_active = 1'b0;
      rst_i       = 1'b0;
      repeat (2) @(posedge clk_i);
      #1;
      chk_reset_outputs();
      rst_i = 1'b1;

      load_words(32'h0000_0100, 2, 32'h1234_5678, 32'hDEAD_BEEF, -1, -1);
      load_words(32'h0000_0103, 2, 32'hCAFE_F00D, 32'h0BAD_C0DE, 2, -1);
      load_words(32'hFFFF_FFFC, 2, 32'h0102_0304, 32'hA5A5_5A5A, -1, 5);

      do_start(32'h0000_0300, 16'd0);
`ifdef PROG_LOADER_CHECKSUM_EN
      send_byte(8'h00);
      wait_done(2);
      chk("cnt0_err", 64'(err_o), 64'd0);
`else
      wait_done(1);
      chk("cnt0_rdy_seen", 64'(rdy_seen), 64'd0);
`endif

`ifdef PROG_LOADER_CHECKSUM_EN
      for (int r = 0; r < 2; r++) begin
         mon_e.a  = 32'h0000_0000;
         mon_e.wd = 32'h0403_0201;
         do_start(32'h0000_0000, 16'd1);
         chk("err_cleared", 64'(err_o), 64'd0);
         sb_q.push_back(mon_e);
         send_byte(8'h01);
         send_byte(8'h02);
         send_byte(8'h03);
         send_byte(8'h04);
         send_byte((r == 0) ? 8'h0A : 8'h0B);
         wait_done(7);
         chk("err_after_sum", 64'(err_o), 64'(r));
      end
      repeat (3) @(posedge clk_i);
      #1;
      chk("err_sticky", 64'(err_o), 64'd1);
      do_start(32'h0000_0000, 16'd0);
      chk("err_clear_on_start", 64'(err_o), 64'd0);
      send_byte(8'h00);
      wait_done(2);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, %0d checks, %0d errors", n_chk, n_err);
      $fatal(1);
   end

endmodule

// File: doc/prog_loader.md
# prog_loader

Initiator for the data-memory load port of the multi-cycle RISC-V system. Receives a program/data image as a byte stream with a valid/ready handshake, assembles little-endian 32-bit words, and drives the memory's `LD`/`WD`/`A` load interface one word at a time while holding the core stopped. Sits beside `risc_v`: its `ld`, `wd`, `a` outputs feed that top's `LD`, `WD`, `A` inputs; `cpu_hold` gates the core's reset.

## Interface
- `ADDR_W`, 32: width of the load address output.
- `CNT_W`, 16: width of the word-count input.
- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous, active-low reset (sampled on rising `clk`; low = reset).
- `start` in 1: one-cycle request to begin a load; honoured only in IDLE.
- `base` in ADDR_W: first word address; latched on accepted `start`; bits [1:0] ignored (treated as 0).
- `count` in CNT_W: number of words to load; latched on accepted `start`.
- `in_valid` in 1: byte-stream valid.
- `in_data` in 8: byte-stream data.
- `in_ready` out 1: loader accepts a byte this cycle.
- `ld` out 1: memory write strobe, one cycle per word.
- `wd` out 32: word to write; valid while `ld`=1.
- `a` out ADDR_W: byte address for `wd`; valid while `ld`=1.
- `cpu_hold` out 1: keep core in reset while 1.
- `busy` out 1: not in IDLE.
- `done` out 1: one-cycle pulse on completion.
- `err` out 1: checksum mismatch, sticky until next accepted `start` (only with checksum feature).

## Operation
- States: IDLE, RECV, WRITE, CHECK (feature only), DONE.
- IDLE: `in_ready`=0. On `start`=1: latch `base`, `count`; clear byte index, word index, checksum, `err`. Go to RECV if `count`≠0, else CHECK (feature on) or DONE.
- RECV: `in_ready`=1. Byte accepted when `in_valid && in_ready`. Byte k (k=0..3) goes to word bits [8k+7:8k]. Checksum += byte (mod 256). After byte 3 → WRITE.
- WRITE: `in_ready`=0; `ld`=1 exactly one cycle; `wd` = assembled word; `a` = base_aligned + 4·word_index (mod 2^ADDR_W). Increment word index. If word_index+1 = count → CHECK (feature on) / DONE; else → RECV.
- CHECK: `in_ready`=1; one byte accepted; `err` ← (byte ≠ running checksum). → DONE.
- DONE: `done`=1 one cycle; → IDLE.
- `cpu_hold`=1 from the cycle after accepted `start` through the DONE cycle inclusive; 0 in IDLE.
- `start` outside IDLE ignored; latched `base`/`count` unchanged.
- `in_valid` with `in_ready`=0: byte not consumed; source must hold it.
- Address wraps modulo 2^ADDR_W with no error.

## Timing
- Reset (`rst`=0 at a clock edge): state IDLE; `in_ready`=0, `ld`=0, `wd`=0, `a`=0, `cpu_hold`=0, `busy`=0, `done`=0, `err`=0. Reset mid-load discards the partial word; words already written stay in memory.
- All outputs registered.
- Per word with back-to-back bytes: 4 RECV cycles + 1 WRITE cycle = 5 cycles; N words with `count`=N: `done` at cycle 5N+1 after the start cycle (+1 with feature).
- `in_ready` and `ld` never 1 in the same cycle.
- Stalled `in_valid` holds state indefinitely; no timeout.

## Configuration
- `PROG_LOADER_CHECKSUM_EN` defined: CHECK state present; after the last word, one trailing byte is consumed and compared to the 8-bit sum of all data bytes; `err` reflects mismatch. `count`=0 still expects the checksum byte (expected value 0x00).
- Not defined: no CHECK state; WRITE of last word (or `count`=0 start) → DONE directly; no trailing byte consumed; `err` tied to 0.

## Test plan
- Reset: hold `rst`=0 two cycles during RECV → all outputs 0, state IDLE, next `start` works normally.
- Load 2 words: `base`=0x100, `count`=2, bytes 78 56 34 12 EF BE AD DE → `ld` pulses with (`a`=0x100, `wd`=0x12345678) and (`a`=0x104, `wd`=0xDEADBEEF); `done` 11 cycles after start (feature off); `cpu_hold` high throughout.
- Back-pressure: drop `in_valid` for 3 cycles mid-word → no `ld`, word and address unaffected; `base`=0x103 → first `a`=0x100.
- Wrap and ignore: `base`=0xFFFFFFFC, `count`=2 → addresses 0xFFFFFFFC then 0x00000000; `start` pulsed during RECV ignored.
- `count`=0 → no `ld`, `done` next cycle after IDLE→DONE, `in_ready` never 1 (feature off).
- Feature on: bytes 01 02 03 04 then 0x0A → `err`=0; repeat with 0x0B → `err`=1, held until next `start`.
